regfile_wb_queue: RTL

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_wb_queue_pkg.sv | 30 +++
 rtl/wbq_fifo.sv | 102 ++++++++++
 rtl/regfile_wb_queue.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared types and constants for the register-file write-back queue.
//   ADDR_W      : register address width
//   DATA_W      : register data width
//   ZERO_REG    : hard-wired zero register; writes to it are discarded
//   wbq_entry_t : one queued write (valid, rd, data)
//   byp_t       : result of a bypass lookup (hit, data)
package regfile_wb_queue_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } byp_t;

  // A write is only architecturally visible when it targets a real register.
  function automatic logic is_live_rd(input logic [ADDR_W-1:0] rd);
    return rd != ZERO_REG;
  endfunction

endpackage

// File: rtl/wbq_fifo.sv
// Circular FIFO holding pending port-B register writes.
// Every slot carries its own valid bit so a newer write from the pipeline
// can cancel queued writes to the same register without disturbing order:
// a cancelled entry keeps its slot and later pops as a no-op.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push         : store push_entry at the tail (ignored when full)
//   push_entry   : entry to store
//   pop          : advance the head (ignored when empty)
//   kill_en      : clear valid on every stored entry whose rd == kill_rd
//   kill_rd      : register address being overwritten by a newer write
//   head_entry   : entry at the head (meaningful when !empty)
//   head_ptr     : index of the oldest slot, for age-ordered scans
//   entries      : raw slot contents, for bypass lookup
//   count        : occupied slots, cancelled ones included
//   full, empty  : occupancy flags
module wbq_fifo
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wbq_entry_t                 push_entry,
  input  logic                       pop,
  input  logic                       kill_en,
  input  logic [ADDR_W-1:0]          kill_rd,
  output wbq_entry_t                 head_entry,
  output logic [$clog2(DEPTH)-1:0]   head_ptr,
  output wbq_entry_t                 entries [DEPTH],
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic do_push;
  logic do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array is reset along with the pointers because the
  // valid bits are state that the bypass and drain logic depend on; a
  // stale valid bit in a free slot must never be observable after reset.
  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; the order of the statements then only matters
  // where two writes target the same bit, and there the later one wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].valid && mem[i].rd == kill_rd) begin
            mem[i].valid <= 1'b0;
          end
        end
      end
      // The push comes after the kill so a same-edge push to the killed
      // address survives: it is younger than the write doing the killing.
      if (do_push) begin
        mem[tail_q] <= push_entry;
        tail_q      <= tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_entry = mem[head_q];
  assign head_ptr   = head_q;
  assign count      = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[i];
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Register-file write-back arbiter with a queue for long-latency results.
// Port A (pipeline write-back) owns the single write port whenever it is
// valid; port-B writes wait in a FIFO and drain in idle write-port cycles.
// Pending writes are visible to readers through a combinational bypass.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   a_valid, a_rd, a_data            : pipeline write, always accepted
//   b_valid, b_rd, b_data, b_ready   : queued write with valid/ready handshake
//   W_en, W_write_rd, W_write_data   : registered register-file write port
//   W_read_rs, W_read_rt             : register-file read addresses
//   byp_rs_hit/_data, byp_rt_hit/_data : newest pending value for rs / rt
//   q_count                          : occupied queue slots
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic [4:0]             a_rd,
  input  logic [31:0]            a_data,
  input  logic                   b_valid,
  input  logic [4:0]             b_rd,
  input  logic [31:0]            b_data,
  output logic                   b_ready,
  output logic                   W_en,
  output logic [4:0]             W_write_rd,
  output logic [31:0]            W_write_data,
  input  logic [4:0]             W_read_rs,
  input  logic [4:0]             W_read_rt,
  output logic                   byp_rs_hit,
  output logic [31:0]            byp_rs_data,
  output logic                   byp_rt_hit,
  output logic [31:0]            byp_rt_data,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbq_entry_t       b_entry;
  wbq_entry_t       head_entry;
  wbq_entry_t       q_entries [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             b_push;
  logic             q_pop;
  logic             a_kill;
  wbq_entry_t       wb_next;
  wbq_entry_t       wb_q;
  byp_t             rs_byp;
  byp_t             rt_byp;

  // Writes to the zero register are queued so the handshake completes,
  // but enter the queue already invalid and so never write or bypass.
  assign b_ready = !full && !rst;
  assign b_push  = b_valid && b_ready;
  assign b_entry = '{valid: is_live_rd(b_rd), rd: b_rd, data: b_data};

  // Port A owns the write port; the queue drains only in cycles it is idle.
  assign q_pop  = !a_valid && !empty;
  assign a_kill = a_valid && is_live_rd(a_rd);

  wbq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (b_push),
    .push_entry (b_entry),
    .pop        (q_pop),
    .kill_en    (a_kill),
    .kill_rd    (a_rd),
    .head_entry (head_entry),
    .head_ptr   (head_ptr),
    .entries    (q_entries),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // Write-port selection. Invalid writes (zero register, killed entries,
  // idle cycles) present rd/data as zero so the port is clean when W_en=0.
  // NOTE: wb_next gets a full default before any branch so every path
  // assigns it and no latch is inferred.
  always_comb begin
    wb_next = '0;
    if (a_valid) begin
      if (is_live_rd(a_rd)) begin
        wb_next = '{valid: 1'b1, rd: a_rd, data: a_data};
      end
    end else if (q_pop) begin
      if (head_entry.valid) begin
        wb_next = head_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_next;
    end
  end

  assign W_en         = wb_q.valid;
  assign W_write_rd   = wb_q.rd;
  assign W_write_data = wb_q.data;
  assign q_count      = count;

  // Newest pending write to addr. The queue is newer than the output
  // register, and within the queue later slots (from head towards tail)
  // are newer, so the scan runs oldest-first and the last match wins.
  function automatic byp_t lookup(input logic [ADDR_W-1:0] addr);
    byp_t             res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (wb_q.valid && wb_q.rd == addr) begin
      res = '{hit: 1'b1, data: wb_q.data};
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PTR_W'(i);
      if (CNT_W'(i) < count && q_entries[idx].valid && q_entries[idx].rd == addr) begin
        res = '{hit: 1'b1, data: q_entries[idx].data};
      end
    end
    if (rst || !is_live_rd(addr)) begin
      res = '0;
    end
    return res;
  endfunction

  always_comb begin
    rs_byp = lookup(W_read_rs);
    rt_byp = lookup(W_read_rt);
  end

  assign byp_rs_hit  = rs_byp.hit;
  assign byp_rs_data = rs_byp.data;
  assign byp_rt_hit  = rt_byp.hit;
  assign byp_rt_data = rt_byp.data;

endmodule
